// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory slave with error detection
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dError
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, nstate;
  logic [3:0] cnt, ncnt;
  logic [31:0] addr, wdata;
  logic rd, wr, err, req;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};
  assign req = MemRead | MemWrite;
  assign err = (rd & wr) | (|addr[1:0]) | (addr < BASE_ADDR) | ({1'b0, addr} >= LIMIT);
  assign idx = AW'((addr - BASE_ADDR) >> 2);
  // next state: accept in IDLE, count down in BUSY so RESP lands LATENCY-1 edges after accept
  always_comb begin
    nstate = state;
    ncnt = cnt;
    if (state == IDLE && req) begin
      nstate = (LATENCY == 1) ? RESP : BUSY;
      ncnt = 4'(LATENCY - 1);
    end else if (state == BUSY) begin
      nstate = (cnt <= 4'd1) ? RESP : BUSY;
      ncnt = (cnt > 4'd1) ? cnt - 4'd1 : 4'd0;
    end else if (state == RESP) begin
      nstate = IDLE;
    end
  end
  // state and countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
    end
  end
  // capture the request at accept time
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr <= dAddress;
      wdata <= dWriteData;
      rd <= MemRead;
      wr <= MemWrite;
    end
  end
  // completion: one-cycle dReady, error flag, and registered load data
  always_ff @(posedge clk) begin
    if (rst) begin
      dReady <= 1'b0;
      dError <= 1'b0;
      dReadData <= 32'h0;
    end else begin
      dReady <= state == RESP;
      dError <= state == RESP && err;
      if (state == RESP && (err || rd)) dReadData <= err ? 32'h0 : mem[idx];
    end
  end
  // stores commit only on a clean RESP edge
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && wr && !err) mem[idx] <= wdata;
  end
endmodule
